// File: rtl/smart_reset_ctrl.sv
// smart_reset_ctrl: SMART trusted-code entry sequencer and fixed-length violation reset.
// Optional trusted-code residence watchdog is compiled in with SMART_WATCHDOG_EN.
module smart_reset_ctrl #(
   parameter logic [15:0] LOW_CODE        = 16'h0200,
   parameter logic [15:0] HIGH_CODE       = 16'h02FF,
   parameter int unsigned HOLD_CYCLES     = 16,
   parameter int unsigned MAX_SAFE_CYCLES = 1024,
   parameter int unsigned CNT_W           = 8
) (
   input  logic             mclk,
   input  logic             puc_rst,
   input  logic [15:0]      ins_addr,
   input  logic             viol_req,
   input  logic             disable_debug,
   output logic             sys_rst,
   output logic             in_code,
   output logic [1:0]       viol_cause,
   output logic [CNT_W-1:0] viol_count
);

   localparam int unsigned     HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HW-1:0]   HOLD_LOAD = HW'(HOLD_CYCLES - 1);
   localparam logic [1:0]      CAUSE_ACCESS = 2'd1;
   localparam logic [1:0]      CAUSE_ENTRY  = 2'd2;

   typedef enum logic [1:0] {IDLE, IN_CODE, HOLD} state_t;

   state_t           state, state_nx;
   logic [HW-1:0]    hold_cnt, hold_nx;
   logic             trig;
   logic [1:0]       trig_cause;
   logic             in_window, at_entry;
   logic             sys_rst_nx, in_code_nx;
   logic [1:0]       cause_nx;
   logic [CNT_W-1:0] count_nx;

`ifdef SMART_WATCHDOG_EN
   localparam int unsigned   WW         = $clog2(MAX_SAFE_CYCLES);
   localparam logic [WW-1:0] WDOG_LAST  = WW'(MAX_SAFE_CYCLES - 1);
   localparam logic [1:0]    CAUSE_WDOG = 2'd3;
   logic [WW-1:0] wdog_cnt, wdog_nx;
`else
   // Watchdog limit has no consumer when the watchdog is compiled out.
   logic [31:0] unused_max_safe;
   assign unused_max_safe = MAX_SAFE_CYCLES;
`endif

   assign in_window = (ins_addr >= LOW_CODE) && (ins_addr <= HIGH_CODE);
   assign at_entry  = (ins_addr == LOW_CODE);

   always_ff @(posedge mclk) begin
      if (puc_rst) begin
         state      <= IDLE;
         hold_cnt   <= '0;
         sys_rst    <= 1'b0;
         in_code    <= 1'b0;
         viol_cause <= '0;
         viol_count <= '0;
`ifdef SMART_WATCHDOG_EN
         wdog_cnt   <= '0;
`endif
      end else begin
         state      <= state_nx;
         hold_cnt   <= hold_nx;
         sys_rst    <= sys_rst_nx;
         in_code    <= in_code_nx;
         viol_cause <= cause_nx;
         viol_count <= count_nx;
`ifdef SMART_WATCHDOG_EN
         wdog_cnt   <= wdog_nx;
`endif
      end
   end

   always_comb begin
      state_nx   = state;
      hold_nx    = hold_cnt;
      trig       = 1'b0;
      trig_cause = '0;
`ifdef SMART_WATCHDOG_EN
      wdog_nx    = wdog_cnt;
`endif
      case (state)
         IDLE: begin
            if (viol_req) begin
               trig       = 1'b1;
               trig_cause = CAUSE_ACCESS;
            end else if (in_window && !at_entry) begin
               trig       = 1'b1;
               trig_cause = CAUSE_ENTRY;
            end else if (at_entry) begin
               state_nx = IN_CODE;
`ifdef SMART_WATCHDOG_EN
               wdog_nx  = '0;
`endif
            end
         end
         IN_CODE: begin
            // viol_req is deliberately ignored: trusted code may touch protected data.
            if (!in_window) begin
               state_nx = IDLE;
            end
`ifdef SMART_WATCHDOG_EN
            else if (wdog_cnt == WDOG_LAST) begin
               trig       = 1'b1;
               trig_cause = CAUSE_WDOG;
            end else begin
               wdog_nx = wdog_cnt + 1'b1;
            end
`endif
         end
         HOLD: begin
            if (hold_cnt == '0) state_nx = IDLE;
            else                hold_nx  = hold_cnt - 1'b1;
         end
         default: state_nx = IDLE;
      endcase
      if (trig) begin
         state_nx = HOLD;
         hold_nx  = HOLD_LOAD;
      end
   end

   // Outputs are registered from the next state so they track the state register.
   always_comb begin
      sys_rst_nx = (state_nx == HOLD) && !disable_debug;
      in_code_nx = (state_nx == IN_CODE);
      cause_nx   = viol_cause;
      count_nx   = viol_count;
      if (trig) begin
         cause_nx = trig_cause;
         if (viol_count != '1) count_nx = viol_count + 1'b1;
      end
   end

endmodule

// File: doc/smart_reset_ctrl.md
# smart_reset_ctrl

Sequencer for the SMART protected-code region and its violation reset. Tracks whether the CPU has legally entered the trusted code window, detects illegal entry, forwarded memory-access violations and (optionally) overlong residence in trusted code. On any violation it latches the cause, counts the event and drives a system reset pulse of fixed length. Sits between the memory-access checker and the openMSP430 reset/clock module, on the `mclk` domain.

## Interface
Parameters:
- `LOW_CODE`, 16'h0200: first (only legal entry) address of trusted code.
- `HIGH_CODE`, 16'h02FF: last address of trusted code, inclusive; `HIGH_CODE >= LOW_CODE`.
- `HOLD_CYCLES`, 16: cycles `sys_rst` stays asserted per violation; must be at least 1.
- `MAX_SAFE_CYCLES`, 1024: watchdog limit for consecutive cycles in trusted code; must be at least 2.
- `CNT_W`, 8: width of the violation counter.

Ports:
- `mclk` in 1: clock.
- `puc_rst` in 1: synchronous, active-high reset. Power-on domain; must not be driven from `sys_rst`.
- `ins_addr` in 16: current instruction address.
- `viol_req` in 1: one-cycle violation pulse from the memory-access checker (protected data touched from untrusted code).
- `disable_debug` in 1: high masks `sys_rst` only.
- `sys_rst` out 1: system reset request.
- `in_code` out 1: high while the FSM is in IN_CODE.
- `viol_cause` out 2: last violation cause. 0 = none, 1 = access, 2 = mid-entry, 3 = watchdog.
- `viol_count` out CNT_W: saturating violation count.

## Operation
The FSM has three states: IDLE, IN_CODE and HOLD. `in_window` means `LOW_CODE <= ins_addr <= HIGH_CODE`, compared unsigned at 16 bits.

IDLE: evaluate in this priority order.
- `viol_req` → HOLD, cause 1.
- `in_window && ins_addr != LOW_CODE` → HOLD, cause 2.
- `ins_addr == LOW_CODE` → IN_CODE, and the watchdog counter clears to 0.
- Otherwise stay in IDLE.
- If `viol_req` and `ins_addr == LOW_CODE` occur in the same cycle, the violation wins.

IN_CODE:
- `viol_req` is ignored, because trusted code is permitted to access protected data.
- `!in_window` → IDLE. This is a legal exit.
- Otherwise the watchdog counter increments. With the watchdog compiled in, a counter value of `MAX_SAFE_CYCLES-1` while still in the window → HOLD, cause 3.
- A jump back to `LOW_CODE` while in IN_CODE does not restart the watchdog.

HOLD:
- The hold counter loads `HOLD_CYCLES-1` on entry and decrements each cycle.
- When it reaches 0, the FSM returns to IDLE.
- `viol_req`, `ins_addr` and the watchdog are ignored during HOLD; nothing is counted.

Every transition into HOLD:
- Loads `viol_cause`.
- Increments `viol_count`, saturating at `2^CNT_W-1`.

Outputs:
- `sys_rst = (state==HOLD) & ~disable_debug`, registered.
- `disable_debug` does not alter state transitions, cause or count.

Reset (`puc_rst` high) sets:
- state IDLE;
- both counters to 0;
- `sys_rst=0`, `in_code=0`, `viol_cause=0`, `viol_count=0`.
- `puc_rst` asserted mid-HOLD aborts the pulse in the following cycle.

## Timing
- All outputs are registered; no combinational path runs from inputs to outputs.
- Trigger observed in cycle N → `sys_rst`, `viol_cause` and `viol_count` update at the edge ending N. `sys_rst` is high for exactly `HOLD_CYCLES` cycles (N+1 .. N+HOLD_CYCLES) and is low in N+HOLD_CYCLES+1.
- If the IDLE trigger condition is still present in the first cycle after HOLD, a new HOLD starts. The minimum `sys_rst` low gap is 1 cycle.
- Entry: `ins_addr==LOW_CODE` in cycle N → `in_code` high from N+1.
- Exit: `!in_window` in cycle M → `in_code` low from M+1.
- Watchdog: the entry cycle is cycle 0. Remaining in the window through cycle `MAX_SAFE_CYCLES` → HOLD from the next cycle. Exiting in cycle `MAX_SAFE_CYCLES-1` or earlier never trips the watchdog.

## Configuration
- Macro `SMART_WATCHDOG_EN`.
- Defined: the watchdog counter and cause 3 are present as described above.
- Undefined: no watchdog counter is implemented. IN_CODE persists until a legal exit, and cause 3 is never produced.

## Test plan
- Legal run: `ins_addr` = 0x0200, 0x0204, 0x02FE, 0x1000 with `viol_req` pulsing mid-run → `in_code` high for 3 cycles, `sys_rst` never high, `viol_count`=0.
- Mid-entry: from IDLE, `ins_addr`=0x0210 → `sys_rst` high for 16 cycles starting the next cycle, `viol_cause`=2, `viol_count`=1.
- Access violation outside code: `viol_req` pulse with `ins_addr`=0x4000 → HOLD with `viol_cause`=1. A second pulse during HOLD leaves the count at 1.
- Priority: `viol_req` together with `ins_addr`=0x0200 → cause 1, `in_code` stays 0.
- Watchdog, with the macro defined and `MAX_SAFE_CYCLES`=8: enter, then loop in the window → `sys_rst` rises 9 cycles after entry with cause 3. With the macro undefined, no reset occurs.
- Corner cases:
  - With `disable_debug`=1, a mid-entry violation gives `sys_rst`=0 but `viol_count` still increments.
  - With `CNT_W`=2, five violations → `viol_count`=3.
  - `puc_rst` in cycle 4 of HOLD → all outputs 0 in the next cycle.
